// File: rtl/mc_ctrl_if.sv
// Sequencer <-> datapath/memory bundle for the multi-cycle RV32I controller.
// The master side is the sequencer; the slave side is the datapath, memory and debug.
interface mc_ctrl_if;
    logic [6:0]  Op;
    logic        Zero;
    logic        mem_ready;
    logic        mem_req;
    logic        mem_we;
    logic        IorD;
    logic        IRWrite;
    logic        PCWrite;
    logic [2:0]  NPCOp;
    logic        RegWrite;
    logic [1:0]  WDSel;
    logic        retire;
    logic [31:0] instret;
    logic        err;
    logic [2:0]  state;

    modport master (
        input  Op, Zero, mem_ready,
        output mem_req, mem_we, IorD, IRWrite, PCWrite, NPCOp, RegWrite, WDSel,
               retire, instret, err, state
    );

    modport slave (
        output Op, Zero, mem_ready,
        input  mem_req, mem_we, IorD, IRWrite, PCWrite, NPCOp, RegWrite, WDSel,
               retire, instret, err, state
    );
endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle RV32I sequencer: FETCH/DECODE/EXEC/MEM/WB over one shared memory port,
// trapping illegal opcodes and memory timeouts, and counting retired instructions.
module mc_ctrl #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic      clk,
    input  logic      rst,
    mc_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_ERR    = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        C_R, C_I, C_LD, C_ST, C_BR, C_JAL, C_JALR, C_LUI
    } cls_t;

    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t      st;
    cls_t        cls;
    logic [7:0]  wait_cnt;
    logic [31:0] instret_q;
    cls_t        dec_cls;
    logic        dec_ok;
    logic        timed_out;

    always_comb begin
        dec_ok  = 1'b1;
        dec_cls = C_R;
        case (bus.Op)
            7'b0110011: dec_cls = C_R;
            7'b0010011: dec_cls = C_I;
            7'b0000011: dec_cls = C_LD;
            7'b0100011: dec_cls = C_ST;
            7'b1100011: dec_cls = C_BR;
            7'b1101111: dec_cls = C_JAL;
            7'b1100111: dec_cls = C_JALR;
            7'b0110111: dec_cls = C_LUI;
            default:    dec_ok  = 1'b0;
        endcase
    end

    // A ready in the last allowed cycle still completes the access.
    assign timed_out = !bus.mem_ready && (wait_cnt == WAIT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st        <= S_FETCH;
            cls       <= C_R;
            wait_cnt  <= '0;
            instret_q <= '0;
        end else begin
            if (bus.retire)
                instret_q <= instret_q + 32'd1;
            case (st)
                S_FETCH: begin
                    if (bus.mem_ready) begin
                        st       <= S_DECODE;
                        wait_cnt <= '0;
                    end else if (timed_out) begin
                        st <= S_ERR;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_DECODE: begin
                    if (dec_ok) begin
                        cls <= dec_cls;
                        st  <= S_EXEC;
                    end else begin
                        st <= S_ERR;
                    end
                end
                S_EXEC: begin
                    wait_cnt <= '0;
                    case (cls)
                        C_BR, C_JAL, C_JALR: st <= S_FETCH;
                        C_LD, C_ST:          st <= S_MEM;
                        default:             st <= S_WB;
                    endcase
                end
                S_MEM: begin
                    if (bus.mem_ready) begin
                        wait_cnt <= '0;
                        st       <= (cls == C_ST) ? S_FETCH : S_WB;
                    end else if (timed_out) begin
                        st <= S_ERR;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_WB: begin
                    wait_cnt <= '0;
                    st       <= S_FETCH;
                end
                S_ERR:   st <= S_ERR;
                default: st <= S_ERR;
            endcase
        end
    end

    // Strobes are gated by rst so an abort never leaves a partial PC/RF write.
    always_comb begin
        bus.mem_req  = 1'b0;
        bus.mem_we   = 1'b0;
        bus.IorD     = 1'b0;
        bus.IRWrite  = 1'b0;
        bus.PCWrite  = 1'b0;
        bus.NPCOp    = 3'b000;
        bus.RegWrite = 1'b0;
        bus.WDSel    = 2'b00;
        if (!rst) begin
            case (st)
                S_FETCH: begin
                    bus.mem_req = 1'b1;
                    bus.IRWrite = bus.mem_ready;
                end
                S_EXEC: begin
                    case (cls)
                        C_BR: begin
                            bus.PCWrite = 1'b1;
                            bus.NPCOp   = {2'b00, bus.Zero};
                        end
                        C_JAL, C_JALR: begin
                            bus.PCWrite  = 1'b1;
                            bus.NPCOp    = (cls == C_JAL) ? 3'b010 : 3'b100;
                            bus.RegWrite = 1'b1;
                            bus.WDSel    = 2'b10;
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    bus.mem_req = 1'b1;
                    bus.IorD    = 1'b1;
                    bus.mem_we  = (cls == C_ST);
                    bus.PCWrite = bus.mem_ready && (cls == C_ST);
                end
                S_WB: begin
                    bus.RegWrite = 1'b1;
                    bus.WDSel    = (cls == C_LD) ? 2'b01 : 2'b00;
                    bus.PCWrite  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.retire  = bus.PCWrite;
    assign bus.instret = instret_q;
    assign bus.err     = (st == S_ERR);
    assign bus.state   = st;
endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: per-instruction expectations from a cycle/strobe model,
// checked by a monitor at every retire, plus directed reset/timeout/illegal/wrap cases.
module tb_mc_ctrl;
    localparam int TO = 4;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_ST   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_BAD  = 7'b0001111;

    typedef struct {
        logic [6:0]  op;
        logic        zero;
        int          fw;
        int          mw;
        int          cycles;
        logic [2:0]  npc;
        logic        rw;
        logic [1:0]  wd;
        logic        we;
        logic [31:0] cnt;
    } ins_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          checks = 0;
    int          errors = 0;
    bit          mon_en = 1'b0;
    ins_t        stimq[$];
    ins_t        expq[$];
    logic [31:0] model_cnt;
    logic [6:0]  ops[8];
    int          n_req;
    int          mcyc;
    logic        m_rw, m_we;
    logic [1:0]  m_wd;
    ins_t        m_e;

    always #5 clk = ~clk;

    mc_ctrl_if bus();
    mc_ctrl #(.MEM_TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, want);
        end
    endtask

    // Expected behaviour per instruction, straight from the cycle-count and strobe rules.
    task automatic push(input logic [6:0] op, input logic z, input int fw, input int mw);
        ins_t t;
        bit   is_mem;
        is_mem = (op == OP_LD) || (op == OP_ST);
        t.op = op; t.zero = z; t.fw = fw; t.mw = mw;
        if (op == OP_BR || op == OP_JAL || op == OP_JALR) t.cycles = 3;
        else if (op == OP_LD)                             t.cycles = 5;
        else                                              t.cycles = 4;
        t.cycles = t.cycles + fw + (is_mem ? mw : 0);
        if (op == OP_BR)        t.npc = {2'b00, z};
        else if (op == OP_JAL)  t.npc = 3'b010;
        else if (op == OP_JALR) t.npc = 3'b100;
        else                    t.npc = 3'b000;
        t.rw  = !(op == OP_BR || op == OP_ST);
        t.wd  = (op == OP_LD) ? 2'b01 : (op == OP_JAL || op == OP_JALR) ? 2'b10 : 2'b00;
        t.we  = (op == OP_ST);
        t.cnt = model_cnt;
        model_cnt = model_cnt + 32'd1;
        stimq.push_back(t);
        expq.push_back(t);
    endtask

    // Drives Op/Zero from the instruction in flight and answers memory after its wait count.
    task automatic run_auto();
        ins_t cur;
        int   acc;
        int   tgt;
        bit   fdone;
        int   budget;
        acc = 0; fdone = 1'b0; budget = 4000;
        cur.op = OP_R; cur.zero = 1'b0; cur.mw = 0;
        while (budget > 0 && expq.size() > 0) begin
            @(negedge clk);
            rst    = 1'b0;
            mon_en = 1'b1;
            budget--;
            #1;
            if (fdone) begin
                cur   = stimq.pop_front();
                fdone = 1'b0;
            end
            bus.Op   = cur.op;
            bus.Zero = cur.zero;
            if (bus.mem_req) begin
                tgt = bus.IorD ? cur.mw : ((stimq.size() > 0) ? stimq[0].fw : 1000);
                if (acc == tgt) begin
                    bus.mem_ready = 1'b1;
                    acc = 0;
                end else begin
                    bus.mem_ready = 1'b0;
                    acc++;
                end
            end else begin
                bus.mem_ready = 1'($urandom_range(0, 1));
                acc = 0;
            end
            #1;
            if (bus.IRWrite) fdone = 1'b1;
        end
        if (expq.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL auto_budget: %0d instructions not retired, expected 0", expq.size());
        end
        mon_en = 1'b0;
        rst = 1'b1;
        bus.mem_ready = 1'b0;
        stimq.delete();
        expq.delete();
    endtask

    task automatic step(input logic [6:0] op, input logic z, input logic rdy);
        @(negedge clk);
        bus.Op = op;
        bus.Zero = z;
        bus.mem_ready = rdy;
        #1;
    endtask

    // Monitor: per-cycle strobe rules, and a scoreboard pop on every retire.
    initial begin
        mcyc = 0; m_rw = 1'b0; m_we = 1'b0; m_wd = 2'b00;
        forever begin
            @(negedge clk);
            #3;
            if (!mon_en) begin
                mcyc = 0; m_rw = 1'b0; m_we = 1'b0; m_wd = 2'b00;
            end else begin
                mcyc++;
                chk("retire_eq_pcwrite", bus.retire, bus.PCWrite);
                chk("no_err", bus.err, 0);
                if (!bus.PCWrite) chk("npcop_idle", bus.NPCOp, 0);
                if (bus.RegWrite) begin
                    m_rw = 1'b1;
                    m_wd = bus.WDSel;
                end else begin
                    chk("wdsel_idle", bus.WDSel, 0);
                end
                if (bus.mem_we) m_we = 1'b1;
                if (bus.retire) begin
                    if (expq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_retire: got retire with empty scoreboard, expected none");
                    end else begin
                        m_e = expq.pop_front();
                        chk("cycles", mcyc, m_e.cycles);
                        chk("npcop", bus.NPCOp, m_e.npc);
                        chk("regwrite", m_rw, m_e.rw);
                        chk("wdsel", m_wd, m_e.wd);
                        chk("mem_we", m_we, m_e.we);
                        chk("instret", bus.instret, m_e.cnt);
                    end
                    mcyc = 0; m_rw = 1'b0; m_we = 1'b0; m_wd = 2'b00;
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        ops = '{OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JAL, OP_JALR, OP_LUI};
        bus.Op = OP_R;
        bus.Zero = 1'b0;
        bus.mem_ready = 1'b0;

        // Reset state, with mem_ready high to expose any ungated strobe.
        repeat (2) @(negedge clk);
        bus.mem_ready = 1'b1;
        #1;
        chk("rst_state", bus.state, 0);
        chk("rst_mem_req", bus.mem_req, 0);
        chk("rst_irwrite", bus.IRWrite, 0);
        chk("rst_pcwrite", bus.PCWrite, 0);
        chk("rst_instret", bus.instret, 0);
        chk("rst_err", bus.err, 0);
        bus.mem_ready = 1'b0;

        // Scoreboarded run: program sequence, wait-state boundaries, then random traffic.
        model_cnt = 32'd0;
        push(OP_I, 1'b0, 0, 0);
        push(OP_LD, 1'b0, 0, 0);
        push(OP_ST, 1'b0, 0, 0);
        push(OP_BR, 1'b1, 0, 0);
        push(OP_JAL, 1'b0, 0, 0);
        push(OP_LD, 1'b0, 0, TO - 1);
        push(OP_ST, 1'b1, TO - 1, TO - 1);
        push(OP_JALR, 1'b0, 2, 0);
        push(OP_BR, 1'b0, 1, 0);
        for (int i = 0; i < 40; i++)
            push(ops[$urandom_range(0, 7)], 1'($urandom_range(0, 1)),
                 $urandom_range(0, TO - 1), $urandom_range(0, TO - 1));
        run_auto();

        // Fetch never answered: exactly TO request cycles, then ERR.
        @(negedge clk);
        rst = 1'b0;
        bus.mem_ready = 1'b0;
        n_req = 0;
        for (int i = 0; i < 10 && bus.state != 3'd7; i++) begin
            #1;
            if (bus.mem_req) n_req++;
            @(negedge clk);
        end
        chk("timeout_req_cycles", n_req, TO);
        repeat (2) @(negedge clk);
        #1;
        chk("timeout_state", bus.state, 7);
        chk("timeout_err", bus.err, 1);
        chk("timeout_mem_req", bus.mem_req, 0);
        rst = 1'b1;
        #1;
        chk("recover_state", bus.state, 0);
        chk("recover_err", bus.err, 0);

        // Illegal opcode.
        @(negedge clk);
        rst = 1'b0;
        bus.Op = OP_BAD;
        bus.mem_ready = 1'b1;
        #1;
        chk("illegal_fetch_irwrite", bus.IRWrite, 1);
        step(OP_BAD, 1'b0, 1'b1);
        chk("illegal_decode_state", bus.state, 1);
        chk("illegal_decode_strobes", {bus.IRWrite, bus.PCWrite, bus.RegWrite, bus.mem_req}, 0);
        step(OP_BAD, 1'b0, 1'b1);
        chk("illegal_err_state", bus.state, 7);
        chk("illegal_err", bus.err, 1);
        chk("illegal_err_strobes", {bus.IRWrite, bus.PCWrite, bus.RegWrite, bus.mem_req}, 0);
        rst = 1'b1;

        // instret wrap, beq not taken/taken, then rst in the MEM cycle of sw.
        @(negedge clk);
        rst = 1'b0;
        bus.Op = OP_BR;
        bus.Zero = 1'b0;
        bus.mem_ready = 1'b1;
        #1;
        force dut.instret_q = 32'hFFFF_FFFF;
        #1;
        release dut.instret_q;
        #1;
        chk("wrap_preload", bus.instret, 32'hFFFF_FFFF);
        step(OP_BR, 1'b0, 1'b0);
        chk("beq0_decode_regwrite", bus.RegWrite, 0);
        step(OP_BR, 1'b0, 1'b0);
        chk("beq0_exec_pcwrite", bus.PCWrite, 1);
        chk("beq0_exec_npcop", bus.NPCOp, 3'b000);
        chk("beq0_exec_regwrite", bus.RegWrite, 0);
        step(OP_BR, 1'b1, 1'b1);
        chk("wrap_instret", bus.instret, 0);
        step(OP_BR, 1'b1, 1'b0);
        step(OP_BR, 1'b1, 1'b0);
        chk("beq1_exec_npcop", bus.NPCOp, 3'b001);
        step(OP_ST, 1'b0, 1'b1);
        chk("after_wrap_instret", bus.instret, 1);
        step(OP_ST, 1'b0, 1'b0);
        step(OP_ST, 1'b0, 1'b0);
        chk("sw_exec_state", bus.state, 2);
        step(OP_ST, 1'b0, 1'b0);
        chk("sw_mem_we", {bus.mem_req, bus.mem_we, bus.IorD}, 3'b111);
        rst = 1'b1;
        #1;
        chk("abort_mem_strobes", {bus.mem_req, bus.mem_we, bus.PCWrite, bus.RegWrite}, 0);
        chk("abort_instret", bus.instret, 0);
        chk("abort_state", bus.state, 0);
        @(negedge clk);
        rst = 1'b0;
        bus.mem_ready = 1'b0;
        #1;
        chk("restart_fetch", {bus.mem_req, bus.IorD}, 2'b10);
        rst = 1'b1;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
